hand_dealer: RTL

HAND_DEALER -- requirements
Module: hand_dealer

---
 rtl/hand_dealer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/hand_dealer.sv
`default_nettype none
// ============================================================================
//  Module      : hand_dealer
//  Description : Deals cards from a free-running 1..13 counter into two
//                three-slot hands (player / banker) and keeps a running
//                mod-10 score for each. Optional build macro FREEZE_CARD_EN
//                adds a freeze_card input that holds the card counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module hand_dealer #(
    parameter int NUM_SLOTS = 3
) (
    input  logic       slow_clock,
    input  logic       reset,
`ifdef FREEZE_CARD_EN
    input  logic       freeze_card,
`endif
    input  logic       deal_valid,
    input  logic       deal_hand,
    output logic       deal_ready,
    input  logic       clear_hands,
    output logic [3:0] pcard1,
    output logic [3:0] pcard2,
    output logic [3:0] pcard3,
    output logic [3:0] dcard1,
    output logic [3:0] dcard2,
    output logic [3:0] dcard3,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic       overflow
);

    localparam int         IDX_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [3:0] CARD_MIN = 4'd1;
    localparam logic [3:0] CARD_MAX = 4'd13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SCORE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       card_q, card_d;
    logic             hand_q, hand_d;
    logic [3:0]       pslot_q [NUM_SLOTS];
    logic [3:0]       pslot_d [NUM_SLOTS];
    logic [3:0]       dslot_q [NUM_SLOTS];
    logic [3:0]       dslot_d [NUM_SLOTS];
    logic [3:0]       pscore_q, pscore_d;
    logic [3:0]       dscore_q, dscore_d;
    logic             ovf_q, ovf_d;
    logic             cnt_hold;
    logic             p_free, d_free;
    logic [IDX_W-1:0] p_idx, d_idx;

`ifdef FREEZE_CARD_EN
    assign cnt_hold = freeze_card;
`else
    assign cnt_hold = 1'b0;
`endif

    // Picture cards (10..13) count zero; the total of three cards is at most 27.
    function automatic logic [3:0] hand_score(input logic [3:0] slots [NUM_SLOTS]);
        logic [5:0] sum;
        sum = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slots[i] <= 4'd9) begin
                sum = sum + {2'b00, slots[i]};
            end
        end
        if (sum >= 6'd20) begin
            sum = sum - 6'd20;
        end else if (sum >= 6'd10) begin
            sum = sum - 6'd10;
        end
        return sum[3:0];
    endfunction

    // Card source: advance 1..13 and wrap, independent of deals and clears.
    always_comb begin
        cnt_d = cnt_q;
        if (!cnt_hold) begin
            cnt_d = (cnt_q == CARD_MAX) ? CARD_MIN : cnt_q + 4'd1;
        end
    end

    // Card counter register.
    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            cnt_q <= CARD_MIN;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Locate the lowest-numbered empty slot of each hand (code 0 = empty).
    always_comb begin
        p_free = 1'b0;
        d_free = 1'b0;
        p_idx  = '0;
        d_idx  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (pslot_q[i] == 4'd0) begin
                p_free = 1'b1;
                p_idx  = IDX_W'(i);
            end
            if (dslot_q[i] == 4'd0) begin
                d_free = 1'b1;
                d_idx  = IDX_W'(i);
            end
        end
    end

    // Next-state and datapath: capture in IDLE, write slot in LOAD, score in SCORE.
    always_comb begin
        state_d  = state_q;
        card_d   = card_q;
        hand_d   = hand_q;
        pslot_d  = pslot_q;
        dslot_d  = dslot_q;
        pscore_d = pscore_q;
        dscore_d = dscore_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (deal_valid) begin
                    state_d = LOAD;
                    card_d  = cnt_q;
                    hand_d  = deal_hand;
                end
            end
            LOAD: begin
                state_d = SCORE;
                if (hand_q) begin
                    if (d_free) begin
                        dslot_d[d_idx] = card_q;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    if (p_free) begin
                        pslot_d[p_idx] = card_q;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            SCORE: begin
                state_d  = IDLE;
                pscore_d = hand_score(pslot_q);
                dscore_d = hand_score(dslot_q);
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clearing overrides everything, including a request on the same edge.
        if (clear_hands) begin
            state_d  = IDLE;
            pscore_d = '0;
            dscore_d = '0;
            ovf_d    = 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                pslot_d[i] = '0;
                dslot_d[i] = '0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Hand, score and flag registers.
    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            card_q   <= '0;
            hand_q   <= 1'b0;
            pscore_q <= '0;
            dscore_q <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                pslot_q[i] <= '0;
                dslot_q[i] <= '0;
            end
        end else begin
            card_q   <= card_d;
            hand_q   <= hand_d;
            pscore_q <= pscore_d;
            dscore_q <= dscore_d;
            ovf_q    <= ovf_d;
            pslot_q  <= pslot_d;
            dslot_q  <= dslot_d;
        end
    end

    assign deal_ready = (state_q == IDLE);
    assign pcard1     = pslot_q[0];
    assign pcard2     = pslot_q[1];
    assign pcard3     = pslot_q[2];
    assign dcard1     = dslot_q[0];
    assign dcard2     = dslot_q[1];
    assign dcard3     = dslot_q[2];
    assign pscore     = pscore_q;
    assign dscore     = dscore_q;
    assign overflow   = ovf_q;

endmodule
`default_nettype wire
